// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode map and FSM state encoding shared by seq_alu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ADD  = 4'd7;
    localparam logic [3:0] OP_SUB  = 4'd8;
    localparam logic [3:0] OP_INC  = 4'd9;
    localparam logic [3:0] OP_DEC  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_DIV  = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_ITER = 2'd1,
        DIV_ITER = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Operation / result handshake bundle for seq_alu.
//               master = issuing side (decoder), slave = the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_hi;
    logic             flag;
    logic             eq_flag;
    logic             div_zero;
    logic             busy;

    modport master (
        output in_valid, opcode, reg_a, reg_b, out_ready,
        input  in_ready, out_valid, acc, acc_hi, flag, eq_flag, div_zero, busy
    );

    modport slave (
        input  in_valid, opcode, reg_a, reg_b, out_ready,
        output in_ready, out_valid, acc, acc_hi, flag, eq_flag, div_zero, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_unit
// Description : Shared one-bit-per-cycle engine for unsigned shift-add MUL
//               and restoring DIV. {r_hi, r_lo} is the working register pair:
//               product {hi, lo} for MUL, {remainder, quotient} for DIV.
//               o_done is asserted during the final step, with o_hi/o_lo
//               carrying the value that step produces.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    input  wire logic             i_is_div,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_lo,
    output logic [WIDTH-1:0]      o_hi
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_run;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;
    logic             w_last;

    // One iteration step: conditional add-and-shift-right for MUL,
    // shift-left-and-trial-subtract for DIV (borrow = MSB of w_diff).
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift = {r_hi, r_lo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
                w_nxt_hi = w_diff[WIDTH-1:0];
                w_nxt_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nxt_hi = w_shift[WIDTH-1:0];
                w_nxt_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_nxt_hi = w_sum[WIDTH:1];
            w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
        w_last = r_run && (r_cnt == LAST_STEP);
    end

    assign o_done = w_last;
    assign o_lo   = w_nxt_lo;
    assign o_hi   = w_nxt_hi;

    // Load operands on start, then advance one step per cycle until the last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_run    <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
            r_is_div <= i_is_div;
            r_run    <= 1'b1;
            r_cnt    <= '0;
        end else if (r_run) begin
            r_hi <= w_nxt_hi;
            r_lo <= w_nxt_lo;
            if (w_last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Handshaked WIDTH-bit ALU with registered results. Single-cycle
//               ops are computed here; MUL and non-zero DIV are handed to
//               alu_iter_unit and complete WIDTH cycles after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    seq_alu_if.slave  bus
);

    state_t r_state;
    state_t w_next_state;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_acc_hi;
    logic             r_flag;
    logic             r_eq;
    logic             r_dz;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_iter;
    logic             w_is_mul;
    logic             w_write;

    logic [WIDTH:0]   w_wide;
    logic             w_zero_flag_op;
    logic [WIDTH-1:0] w_sc_acc;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_flag;
    logic             w_sc_eq;
    logic             w_sc_dz;

    logic [WIDTH-1:0] w_wr_acc;
    logic [WIDTH-1:0] w_wr_hi;
    logic             w_wr_flag;
    logic             w_wr_eq;
    logic             w_wr_dz;

    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_lo;
    logic [WIDTH-1:0] w_iter_hi;

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start_iter),
        .i_is_div (!w_is_mul),
        .i_a      (bus.reg_a),
        .i_b      (bus.reg_b),
        .o_done   (w_iter_done),
        .o_lo     (w_iter_lo),
        .o_hi     (w_iter_hi)
    );

    // Single-cycle result from the operands presented this cycle; only
    // meaningful when it is written at an accept edge.
    always_comb begin
        w_wide         = '0;
        w_zero_flag_op = 1'b0;
        w_sc_acc       = '0;
        w_sc_hi        = '0;
        w_sc_flag      = 1'b0;
        w_sc_eq        = 1'b0;
        w_sc_dz        = 1'b0;
        case (bus.opcode)
            OP_OR:  begin w_sc_acc = bus.reg_a | bus.reg_b; w_zero_flag_op = 1'b1; end
            OP_AND: begin w_sc_acc = bus.reg_a & bus.reg_b; w_zero_flag_op = 1'b1; end
            OP_NOT: begin w_sc_acc = ~bus.reg_a;            w_zero_flag_op = 1'b1; end
            OP_XOR: begin w_sc_acc = bus.reg_a ^ bus.reg_b; w_zero_flag_op = 1'b1; end
            OP_SUB: begin w_sc_acc = bus.reg_a - bus.reg_b; w_zero_flag_op = 1'b1; end
            OP_SHL: w_sc_acc = {bus.reg_a[WIDTH-2:0], 1'b0};
            OP_SHR: w_sc_acc = {1'b0, bus.reg_a[WIDTH-1:1]};
            OP_ROL: w_sc_acc = {bus.reg_a[WIDTH-2:0], bus.reg_a[WIDTH-1]};
            OP_ROR: w_sc_acc = {bus.reg_a[0], bus.reg_a[WIDTH-1:1]};
            OP_DEC: w_sc_acc = bus.reg_a - 1'b1;
            OP_ADD: begin
                w_wide    = {1'b0, bus.reg_a} + {1'b0, bus.reg_b};
                w_sc_acc  = w_wide[WIDTH-1:0];
                w_sc_flag = w_wide[WIDTH];
            end
            OP_INC: begin
                w_wide    = {1'b0, bus.reg_a} + (WIDTH+1)'(1);
                w_sc_acc  = w_wide[WIDTH-1:0];
                w_sc_flag = w_wide[WIDTH];
            end
            OP_CMP: begin
                w_sc_acc  = bus.reg_a;
                w_sc_flag = bus.reg_a > bus.reg_b;
                w_sc_eq   = bus.reg_a == bus.reg_b;
            end
            OP_DIV: begin
                // Only the divide-by-zero case reaches the registers from here.
                w_sc_acc = '1;
                w_sc_hi  = bus.reg_a;
                w_sc_dz  = 1'b1;
            end
            default: begin
                // MUL goes through the iter unit; reserved yields all zeros.
                w_sc_acc = '0;
            end
        endcase
        if (w_zero_flag_op) begin
            w_sc_flag = (w_sc_acc == '0);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake, next state and result-register write selection.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
        w_accept     = bus.in_valid && w_in_ready;
        w_is_mul     = (bus.opcode == OP_MUL);
        w_start_iter = w_accept &&
                       (w_is_mul || ((bus.opcode == OP_DIV) && (bus.reg_b != '0)));
        w_write      = 1'b0;
        w_wr_acc     = w_sc_acc;
        w_wr_hi      = w_sc_hi;
        w_wr_flag    = w_sc_flag;
        w_wr_eq      = w_sc_eq;
        w_wr_dz      = w_sc_dz;
        case (r_state)
            IDLE: begin
                if (w_start_iter) begin
                    w_next_state = w_is_mul ? MUL_ITER : DIV_ITER;
                end else if (w_accept) begin
                    w_write = 1'b1;
                end
            end
            MUL_ITER, DIV_ITER: begin
                if (w_iter_done) begin
                    w_next_state = IDLE;
                    w_write      = 1'b1;
                    w_wr_acc     = w_iter_lo;
                    w_wr_hi      = w_iter_hi;
                    w_wr_eq      = 1'b0;
                    w_wr_dz      = 1'b0;
                    w_wr_flag    = (r_state == MUL_ITER) ? (w_iter_hi != '0)
                                                         : (w_iter_lo == '0);
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Result registers: a new result wins over a same-edge consume;
    // otherwise hold until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_acc_hi    <= '0;
            r_flag      <= 1'b0;
            r_eq        <= 1'b0;
            r_dz        <= 1'b0;
        end else if (w_write) begin
            r_out_valid <= 1'b1;
            r_acc       <= w_wr_acc;
            r_acc_hi    <= w_wr_hi;
            r_flag      <= w_wr_flag;
            r_eq        <= w_wr_eq;
            r_dz        <= w_wr_dz;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.acc       = r_acc;
    assign bus.acc_hi    = r_acc_hi;
    assign bus.flag      = r_flag;
    assign bus.eq_flag   = r_eq;
    assign bus.div_zero  = r_dz;
    assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire
